// File: rtl/return_coin_dispenser_if.sv
// -----------------------------------------------------------------------------
// return_coin_dispenser_if
// Coin chute handshake between the change-return engine and the coin chute.
//   o_return_coin  : coin vector presented (bit2=1000, bit1=500, bit0=100)
//   o_return_valid : a coin is presented, held until accepted
//   i_coin_ready   : chute accepts the presented coin this cycle
// Modports: master = dispenser side, slave = chute side.
// -----------------------------------------------------------------------------
interface return_coin_dispenser_if #(
    parameter int NUM_COINS = 3
) ();
    logic [NUM_COINS-1:0] o_return_coin;
    logic                 o_return_valid;
    logic                 i_coin_ready;

    modport master (
        output o_return_coin,
        output o_return_valid,
        input  i_coin_ready
    );

    modport slave (
        input  o_return_coin,
        input  o_return_valid,
        output i_coin_ready
    );
endinterface

// File: rtl/return_coin_dispenser.sv
// -----------------------------------------------------------------------------
// return_coin_dispenser
// Change-return engine: on a return request or timeout, captures the machine
// balance and pays it out greedily (largest coin first) over the chute
// handshake, accumulating the amount returned.
//
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   i_trigger_return    : user return request
//   i_timeout           : wait-time expired
//   current_total       : machine balance, captured at session start
//   chute (master)      : o_return_coin / o_return_valid / i_coin_ready
//   o_return_total      : sum of coins accepted in current/last session
//   o_residue           : amount below 100 left undispensed
//   o_busy              : session in progress (PAY or FIN)
//   o_done              : one-cycle pulse at session end
//
// Build option: define RETURN_COIN_BURST_EN to present up to one coin of each
// denomination per beat instead of a single one-hot coin.
// -----------------------------------------------------------------------------
module return_coin_dispenser #(
    parameter int TOTAL_BITS = 31,
    parameter int NUM_COINS  = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_trigger_return,
    input  logic                  i_timeout,
    input  logic [TOTAL_BITS-1:0] current_total,
    return_coin_dispenser_if.master chute,
    output logic [TOTAL_BITS-1:0] o_return_total,
    output logic [TOTAL_BITS-1:0] o_residue,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam logic [TOTAL_BITS-1:0] C_1000 = TOTAL_BITS'(1000);
    localparam logic [TOTAL_BITS-1:0] C_500  = TOTAL_BITS'(500);
    localparam logic [TOTAL_BITS-1:0] C_100  = TOTAL_BITS'(100);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PAY  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [TOTAL_BITS-1:0] r_remaining, w_remaining_nxt;
    logic [TOTAL_BITS-1:0] r_return_total, w_return_total_nxt;
    logic [TOTAL_BITS-1:0] r_residue, w_residue_nxt;

    logic [NUM_COINS-1:0]  w_coin;
    logic [TOTAL_BITS-1:0] w_rem_after;
    logic [TOTAL_BITS-1:0] w_beat_value;
    logic                  w_valid;
    logic                  w_accept;

    // Coin selection from the registered remaining amount. w_rem_after is what
    // remains if the beat is accepted; the beat value is derived from it so
    // both build variants share the same accumulate/subtract path.
    always_comb begin
        w_coin      = '0;
        w_rem_after = r_remaining;
`ifdef RETURN_COIN_BURST_EN
        if (w_rem_after >= C_1000) begin
            w_coin[2]   = 1'b1;
            w_rem_after = w_rem_after - C_1000;
        end
        if (w_rem_after >= C_500) begin
            w_coin[1]   = 1'b1;
            w_rem_after = w_rem_after - C_500;
        end
        if (w_rem_after >= C_100) begin
            w_coin[0]   = 1'b1;
            w_rem_after = w_rem_after - C_100;
        end
`else
        if (r_remaining >= C_1000) begin
            w_coin[2]   = 1'b1;
            w_rem_after = r_remaining - C_1000;
        end else if (r_remaining >= C_500) begin
            w_coin[1]   = 1'b1;
            w_rem_after = r_remaining - C_500;
        end else if (r_remaining >= C_100) begin
            w_coin[0]   = 1'b1;
            w_rem_after = r_remaining - C_100;
        end
`endif
        w_beat_value = r_remaining - w_rem_after;
    end

    assign w_valid  = (r_state == PAY) && (r_remaining >= C_100);
    assign w_accept = w_valid && chute.i_coin_ready;

    assign chute.o_return_valid = w_valid;
    assign chute.o_return_coin  = w_valid ? w_coin : '0;

    always_comb begin
        w_state_nxt        = r_state;
        w_remaining_nxt    = r_remaining;
        w_return_total_nxt = r_return_total;
        w_residue_nxt      = r_residue;
        case (r_state)
            IDLE: begin
                if (i_trigger_return || i_timeout) begin
                    w_state_nxt        = PAY;
                    w_remaining_nxt    = current_total;
                    w_return_total_nxt = '0;
                    w_residue_nxt      = '0;
                end
            end
            PAY: begin
                // Leave PAY on the edge that accepts the last coin so the
                // session takes N coins + 1 cycle; a start balance below 100
                // has no coin to present and drops straight to FIN.
                if (!w_valid) begin
                    w_state_nxt   = FIN;
                    w_residue_nxt = r_remaining;
                end else if (w_accept) begin
                    w_remaining_nxt    = w_rem_after;
                    w_return_total_nxt = r_return_total + w_beat_value;
                    if (w_rem_after < C_100) begin
                        w_state_nxt   = FIN;
                        w_residue_nxt = w_rem_after;
                    end
                end
            end
            FIN:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_remaining    <= '0;
            r_return_total <= '0;
            r_residue      <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_remaining    <= w_remaining_nxt;
            r_return_total <= w_return_total_nxt;
            r_residue      <= w_residue_nxt;
        end
    end

    assign o_return_total = r_return_total;
    assign o_residue      = r_residue;
    assign o_busy         = (r_state != IDLE);
    assign o_done         = (r_state == FIN);

endmodule

// File: doc/return_coin_dispenser.md
# return_coin_dispenser

Change-return engine for the vending machine. On a user return request or a wait-time expiry, it captures the machine balance and pays it out as coins. Payout is greedy: the largest coin first, one coin per handshake with the coin chute. The block drives the `o_return_coin` vector and the running returned amount that the balance-calculation logic subtracts from `current_total`.

## Interface
Parameters:
- `TOTAL_BITS`, default 31: width of all money quantities (matches `kTotalBits`).
- `NUM_COINS`, default 3: coin vector width (matches `kNumCoins`).
- Coin encoding is fixed: bit2 = 1000, bit1 = 500, bit0 = 100.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `i_trigger_return`  in  1  user return request, level sampled at the clock edge.
- `i_timeout`  in  1  wait-time expired, from the timer logic.
- `current_total`  in  TOTAL_BITS  machine balance; sampled only at session start.
- `i_coin_ready`  in  1  coin chute accepts the presented coin this cycle.
- `o_return_coin`  out  NUM_COINS  coin(s) presented; valid only with `o_return_valid`.
- `o_return_valid`  out  1  a coin is presented.
- `o_return_total`  out  TOTAL_BITS  sum of coins accepted in the current or last session.
- `o_residue`  out  TOTAL_BITS  amount below 100 that could not be dispensed.
- `o_busy`  out  1  session in progress.
- `o_done`  out  1  one-cycle pulse at session end.

## Operation
- **States:**
  - `IDLE`: start condition is `i_trigger_return | i_timeout`.
  - `PAY`: coins are presented on the chute handshake.
  - `FIN`: one-cycle end state.
- **IDLE → PAY:** on the start condition, in the same edge:
  - `remaining` <= `current_total`
  - `o_return_total` <= 0
  - `o_residue` <= 0
- **PAY coin selection** (non-burst), from the registered `remaining`:
  - `remaining` >= 1000 → 3'b100
  - else `remaining` >= 500 → 3'b010
  - else `remaining` >= 100 → 3'b001
- **PAY handshake:**
  - `o_return_valid` = 1 in PAY whenever `remaining` >= 100.
  - On `o_return_valid & i_coin_ready`: `remaining` -= coin value and `o_return_total` += coin value.
  - `o_return_coin` and `o_return_valid` hold stable until accepted.
- **PAY → FIN:** when `remaining` < 100.
  - `o_residue` <= `remaining`.
  - `o_return_valid` = 0.
- **FIN:** `o_done` = 1 for exactly one cycle, then → IDLE.
- **Busy:** `o_busy` = 1 in PAY and FIN.
- **Start conditions during a session:** `i_trigger_return` and `i_timeout` are ignored in PAY and FIN; no queuing.
- **Simultaneous start:** trigger and timeout in the same cycle start exactly one session.
- **Zero balance:** `current_total` = 0 at start goes IDLE → PAY → FIN with no coin presented. `o_done` pulses and `o_return_total` = 0.
- **Balance changes mid-session:** ignored. The captured value is authoritative.
- **Arithmetic:** unsigned TOTAL_BITS. Subtraction cannot underflow because a coin is never selected above `remaining`.

## Timing
- **Reset values:** state = IDLE; every output = 0, including `o_return_total` and `o_residue`.
- **Reset mid-session:** asynchronous reset returns to IDLE immediately. A partially paid session is dropped; no `o_done` is issued.
- **First coin:** `o_return_valid` rises in the first cycle after the start edge (latency 1).
- **Throughput:** one accepted coin per cycle with `i_coin_ready` held high. Back-pressure stalls indefinitely.
- **Register timing:** `o_return_total` updates on the edge that accepts a coin. It holds its value after `o_done` until the next session start.
- **Session length:** for N coins with no stalls, `o_done` is high in cycle N+1 after the start edge.

## Configuration
- **Macro:** `RETURN_COIN_BURST_EN`.
- **Defined:** each beat may present multiple coins, at most one of each denomination. Bits are chosen greedily:
  - bit2 if `remaining` >= 1000
  - bit1 if (`remaining` − bit2·1000) >= 500
  - bit0 if (`remaining` − bit2·1000 − bit1·500) >= 100
  - On acceptance, the full beat sum is subtracted and accumulated.
- **Not defined:** `o_return_coin` is always one-hot (the behaviour in Operation).

## Test plan
- `current_total` = 1700, trigger pulse, `i_coin_ready` = 1 → coins 100b, 010b, 001b, 001b on consecutive cycles; `o_return_total` = 1700; `o_residue` = 0; `o_done` 5 cycles after the start edge.
- `current_total` = 1500, `i_coin_ready` low for 3 cycles → 100b held stable 3 cycles, then accepted; next 010b; `o_return_total` = 1500.
- `current_total` = 250, timeout pulse → two 001b coins; `o_return_total` = 200; `o_residue` = 50.
- `current_total` = 2600, trigger, reset_n asserted after first accepted coin → all outputs 0 immediately, no `o_done`; new trigger with 600 → 010b, 001b.
- Trigger asserted again mid-session with `current_total` changing to 900 → ignored; original captured amount is paid exactly.
- `RETURN_COIN_BURST_EN` defined, `current_total` = 1700 → beats 111b (1600), then 001b; `o_return_total` = 1700; `o_done` 3 cycles after the start edge.
